// File: rtl/instr_mem_loader.sv
// Boot loader for the byte-wide instruction RAM: 32-bit words in over valid/ready, four little-endian byte writes out.
// Define LOADER_CHECKSUM_EN to add a running mod-256 checksum of every byte written.
module instr_mem_loader #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     word_valid,
    input  logic [DATA_WIDTH-1:0]    word_data,
    input  logic                     word_last,
    output logic                     word_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] words_written,
    output logic [7:0]               checksum
);

    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} stateT;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_TOP = '1;

    stateT                    state;
    logic [ADDRESS_WIDTH-1:0] ptr;
    logic [ADDRESS_WIDTH-1:0] memAddrQ;
    logic [ADDRESS_WIDTH-1:0] count;
    logic [7:0]               memWdataQ;
    logic [DATA_WIDTH-1:0]    wordQ;
    logic                     lastQ;
    logic [1:0]               byteIdx;
    logic [1:0]               nextIdx;

    assign nextIdx = byteIdx + 2'd1;

    // NOTE: start gates the strobe combinationally so a restart cancels the write already on the bus this cycle.
    assign mem_we        = (state == WRITE) && !start;
    assign word_ready    = (state == ACCEPT);
    assign busy          = (state == ACCEPT) || (state == WRITE);
    assign done          = (state == DONE);
    assign err           = (state == ERROR);
    assign mem_addr      = memAddrQ;
    assign mem_wdata     = memWdataQ;
    assign words_written = count;

    // byteIdx names the byte currently on the bus; ptr is the address of the next byte to issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= BASE_ADDR;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            count     <= '0;
            wordQ     <= '0;
            lastQ     <= 1'b0;
            byteIdx   <= 2'd0;
        end else if (start) begin
            state   <= ACCEPT;
            ptr     <= BASE_ADDR;
            count   <= '0;
            byteIdx <= 2'd0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (word_valid) begin
                        wordQ     <= word_data;
                        lastQ     <= word_last;
                        byteIdx   <= 2'd0;
                        memAddrQ  <= ptr;
                        memWdataQ <= word_data[7:0];
                        ptr       <= ptr + ADDR_ONE;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (byteIdx == 2'd3) begin
                        count <= count + ADDR_ONE;
                        if (lastQ) begin
                            state <= DONE;
                        end else if (memAddrQ == ADDR_TOP) begin
                            state <= ERROR;
                        end else begin
                            state <= ACCEPT;
                        end
                    end else if (memAddrQ == ADDR_TOP) begin
                        // Bytes remain but the address space is exhausted: drop them rather than wrap to 0.
                        state <= ERROR;
                    end else begin
                        byteIdx   <= nextIdx;
                        memAddrQ  <= ptr;
                        memWdataQ <= wordQ[{nextIdx, 3'b000} +: 8];
                        ptr       <= ptr + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sumQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumQ <= 8'h00;
        end else if (start) begin
            sumQ <= 8'h00;
        end else if (mem_we) begin
            sumQ <= sumQ + memWdataQ;
        end
    end

    assign checksum = sumQ;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed timing cases plus randomized streams against a byte-level model.
// Three instances cover base address 0 and the two top-of-memory overflow cases.
module tb_instr_mem_loader;

    localparam int AW = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        wordValid = 1'b0;
    logic        wordLast  = 1'b0;
    logic [31:0] wordData  = '0;

    logic readyA, weA, busyA, doneA, errA;
    logic readyB, weB, busyB, doneB, errB;
    logic readyC, weC, busyC, doneC, errC;
    logic [AW-1:0] addrA, wwA, addrB, wwB, addrC, wwC;
    logic [7:0]    wdataA, csA, wdataB, csB, wdataC, csC;

    int tests    = 0;
    int fails    = 0;
    int cycle    = 0;
    int overlapA = 0;

    logic [23:0] gotA[$];
    logic [23:0] gotB[$];
    logic [23:0] gotC[$];

    logic [31:0] stimW[$];
    bit          stimL[$];
    int          stimGap[$];

    logic [23:0] expW[$];
    bit          expDone;
    bit          expErr;
    int          expCount;
    int          expAccepted;
    logic [7:0]  expSum;

    instr_mem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(16'h0000)) dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .word_valid(wordValid), .word_data(wordData),
        .word_last(wordLast), .word_ready(readyA), .mem_we(weA), .mem_addr(addrA), .mem_wdata(wdataA),
        .busy(busyA), .done(doneA), .err(errA), .words_written(wwA), .checksum(csA)
    );

    instr_mem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(16'hFFFE)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start), .word_valid(wordValid), .word_data(wordData),
        .word_last(wordLast), .word_ready(readyB), .mem_we(weB), .mem_addr(addrB), .mem_wdata(wdataB),
        .busy(busyB), .done(doneB), .err(errB), .words_written(wwB), .checksum(csB)
    );

    instr_mem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .BASE_ADDR(16'hFFFC)) dutC (
        .clk(clk), .rst_n(rst_n), .start(start), .word_valid(wordValid), .word_data(wordData),
        .word_last(wordLast), .word_ready(readyC), .mem_we(weC), .mem_addr(addrC), .mem_wdata(wdataC),
        .busy(busyC), .done(doneC), .err(errC), .words_written(wwC), .checksum(csC)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Byte writes are recorded mid-cycle, well away from the active edge.
    always @(negedge clk) begin
        if (weA === 1'b1) gotA.push_back({addrA, wdataA});
        if (weB === 1'b1) gotB.push_back({addrB, wdataB});
        if (weC === 1'b1) gotC.push_back({addrC, wdataC});
        if (readyA === 1'b1 && weA === 1'b1) overlapA++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish on its own");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected write list from the image layout: word i, byte b lands at base + 4*i + b.
    function automatic void runModel(input int base);
        int addr;
        logic [31:0] w;
        logic [7:0] bv;
        addr = base;
        expW.delete();
        expDone = 1'b0;
        expErr = 1'b0;
        expCount = 0;
        expAccepted = 0;
        expSum = 8'h00;
        for (int i = 0; i < stimW.size(); i++) begin
            w = stimW[i];
            for (int b = 0; b < 4; b++) begin
                if (addr > (1 << AW) - 1) begin
                    expErr = 1'b1;
                    return;
                end
                if (b == 0) expAccepted++;
                bv = w[8*b +: 8];
                expW.push_back({addr[AW-1:0], bv});
                expSum = expSum + bv;
                addr++;
            end
            expCount++;
            if (stimL[i]) begin
                expDone = 1'b1;
                return;
            end
        end
    endfunction

    function automatic logic rdy(input int which);
        case (which)
            0:       return readyA;
            1:       return readyB;
            default: return readyC;
        endcase
    endfunction

    function automatic logic finished(input int which);
        case (which)
            0:       return doneA | errA;
            1:       return doneB | errB;
            default: return doneC | errC;
        endcase
    endfunction

    task automatic pulseStart();
        gotA.delete();
        gotB.delete();
        gotC.delete();
        overlapA = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Each word is offered stimGap[i] cycles after the loader becomes ready.
    task automatic drive(input int which);
        int t;
        for (int i = 0; i < expAccepted; i++) begin
            t = 0;
            while (!rdy(which) && t < 40) begin
                step();
                t++;
            end
            check($sformatf("ready_wait%0d", i), 32'(t < 40), 32'd1);
            repeat (stimGap[i]) step();
            wordValid = 1'b1;
            wordData  = stimW[i];
            wordLast  = stimL[i];
            step();
            wordValid = 1'b0;
        end
    endtask

    task automatic waitEnd(input int which, input string tag);
        int t;
        t = 0;
        while (!finished(which) && t < 60) begin
            step();
            t++;
        end
        check({tag, "_end_timeout"}, 32'(t < 60), 32'd1);
    endtask

    task automatic compare(input int which, input string tag);
        logic [23:0] g[$];
        logic d, e, r, b;
        logic [AW-1:0] ww;
        logic [7:0] cs;
        case (which)
            0:       begin g = gotA; d = doneA; e = errA; r = readyA; b = busyA; ww = wwA; cs = csA; end
            1:       begin g = gotB; d = doneB; e = errB; r = readyB; b = busyB; ww = wwB; cs = csB; end
            default: begin g = gotC; d = doneC; e = errC; r = readyC; b = busyC; ww = wwC; cs = csC; end
        endcase
        check({tag, "_nwrites"}, 32'(g.size()), 32'(expW.size()));
        for (int i = 0; i < expW.size() && i < g.size(); i++)
            check($sformatf("%s_write%0d", tag, i), 32'(g[i]), 32'(expW[i]));
        check({tag, "_done"}, 32'(d), 32'(expDone));
        check({tag, "_err"}, 32'(e), 32'(expErr));
        check({tag, "_words_written"}, 32'(ww), 32'(expCount));
        check({tag, "_checksum"}, 32'(cs), 32'(expSum));
        check({tag, "_busy"}, 32'(b), 32'd0);
        check({tag, "_ready"}, 32'(r), 32'd0);
    endtask

    task automatic runStream(input int which, input int base, input string tag);
        int c0;
        int expCycles;
        runModel(base);
`ifndef LOADER_CHECKSUM_EN
        expSum = 8'h00;
`endif
        pulseStart();
        c0 = cycle;
        drive(which);
        waitEnd(which, tag);
        if (which == 0) begin
            expCycles = 0;
            for (int i = 0; i < stimW.size(); i++) expCycles += stimGap[i] + 5;
            check({tag, "_cycles"}, 32'(cycle - c0), 32'(expCycles));
            check({tag, "_ready_during_write"}, 32'(overlapA), 32'd0);
        end
        compare(which, tag);
    endtask

    task automatic setStim(input int n, input bit lastAtEnd, input int gapMax);
        stimW.delete();
        stimL.delete();
        stimGap.delete();
        for (int i = 0; i < n; i++) begin
            stimW.push_back($urandom());
            stimL.push_back(lastAtEnd && (i == n - 1));
            stimGap.push_back(int'($urandom_range(gapMax, 0)));
        end
    endtask

    initial begin
        logic [7:0] sw[4];
        sw = '{8'h93, 8'h00, 8'h40, 8'h00};

        // Reset state
        step();
        check("rst_ready", 32'(readyA), 32'd0);
        check("rst_we", 32'(weA), 32'd0);
        check("rst_addr", 32'(addrA), 32'd0);
        check("rst_wdata", 32'(wdataA), 32'd0);
        check("rst_busy", 32'(busyA), 32'd0);
        check("rst_done", 32'(doneA), 32'd0);
        check("rst_err", 32'(errA), 32'd0);
        check("rst_ww", 32'(wwA), 32'd0);
        check("rst_cs", 32'(csA), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_ready", 32'(readyA), 32'd0);

        // Single word, cycle-exact
        gotA.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        check("sw_accept_ready", 32'(readyA), 32'd1);
        check("sw_accept_busy", 32'(busyA), 32'd1);
        wordValid = 1'b1;
        wordData  = 32'h00400093;
        wordLast  = 1'b1;
        step();
        wordValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sw_we%0d", i), 32'(weA), 32'd1);
            check($sformatf("sw_addr%0d", i), 32'(addrA), 32'(i));
            check($sformatf("sw_data%0d", i), 32'(wdataA), 32'(sw[i]));
            check($sformatf("sw_ready%0d", i), 32'(readyA), 32'd0);
            step();
        end
        check("sw_done", 32'(doneA), 32'd1);
        check("sw_we_after", 32'(weA), 32'd0);
        check("sw_ww", 32'(wwA), 32'd1);
        check("sw_busy_after", 32'(busyA), 32'd0);
        check("sw_addr_hold", 32'(addrA), 32'd3);
        wordValid = 1'b1;
        repeat (3) step();
        check("sw_done_ignores_valid_ready", 32'(readyA), 32'd0);
        check("sw_done_ignores_valid_we", 32'(weA), 32'd0);
        check("sw_done_held", 32'(doneA), 32'd1);
        wordValid = 1'b0;

        // Three-word stream, 2-cycle gaps
        setStim(3, 1'b1, 0);
        for (int i = 0; i < 3; i++) stimGap[i] = 2;
        runStream(0, 0, "stream3");

        // Randomized streams
        for (int k = 0; k < 4; k++) begin
            setStim(int'($urandom_range(5, 1)), 1'b1, 3);
            runStream(0, 0, $sformatf("rand%0d", k));
        end

        // Restart during the third byte write
        gotA.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        wordValid = 1'b1;
        wordData  = 32'h11223344;
        wordLast  = 1'b0;
        step();
        wordValid = 1'b0;
        step();
        step();
        check("rs_third_we_pre", 32'(weA), 32'd1);
        check("rs_third_addr", 32'(addrA), 32'd2);
        start = 1'b1;
        #1;
        check("rs_third_suppressed", 32'(weA), 32'd0);
        step();
        start = 1'b0;
        check("rs_accept_ready", 32'(readyA), 32'd1);
        check("rs_ww_cleared", 32'(wwA), 32'd0);
        check("rs_nwrites_before", 32'(gotA.size()), 32'd2);
        stimW = '{32'hCAFEF00D};
        stimL = '{1'b1};
        stimGap = '{0};
        runModel(0);
`ifndef LOADER_CHECKSUM_EN
        expSum = 8'h00;
`endif
        gotA.delete();
        drive(0);
        waitEnd(0, "rs");
        compare(0, "rs");

        // Checksum image
        stimW = '{32'h01020304, 32'hFF000001};
        stimL = '{1'b0, 1'b1};
        stimGap = '{1, 0};
        runStream(0, 0, "csum");

        // Overflow with bytes left over
        stimW = '{32'hAABBCCDD};
        stimL = '{1'b0};
        stimGap = '{0};
        runStream(1, 16'hFFFE, "ovf_partial");

        // Last byte exactly at the top of memory
        stimL = '{1'b1};
        runStream(2, 16'hFFFC, "ovf_exact");

        // Top of memory reached but another word expected
        stimW = '{32'h0BADF00D, 32'h12345678};
        stimL = '{1'b0, 1'b1};
        stimGap = '{0, 0};
        runStream(2, 16'hFFFC, "ovf_more");

        // Asynchronous reset between edges while writing
        stimW = '{32'h5A5AA5A5};
        stimL = '{1'b1};
        stimGap = '{0};
        runModel(0);
        pulseStart();
        drive(0);
        step();
        check("ar_pre_addr", 32'(addrA), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_we", 32'(weA), 32'd0);
        check("ar_addr", 32'(addrA), 32'd0);
        check("ar_wdata", 32'(wdataA), 32'd0);
        check("ar_busy", 32'(busyA), 32'd0);
        check("ar_ready", 32'(readyA), 32'd0);
        check("ar_ww", 32'(wwA), 32'd0);
        check("ar_cs", 32'(csA), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        step();
        check("ar_idle_ready", 32'(readyA), 32'd0);
        check("ar_idle_busy", 32'(busyA), 32'd0);
        check("ar_idle_we", 32'(weA), 32'd0);
        check("ar_idle_done", 32'(doneA), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
